// File: rtl/dnnweaver_pkg.sv
`default_nettype none
// ============================================================================
// Package : dnnweaver_pkg
// Purpose : Shared helpers for dnnweaver datapath blocks.
// Contents: clog2() - ceiling log2, usable in constant expressions.
// Revision: 1.0 - initial release
// ============================================================================
package dnnweaver_pkg;

  // Ceiling log2. Returns 0 for values of 0 or 1. Callers that size
  // counters pass (N+1), which is always >= 2.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module  : register_stage_elastic
// Purpose : One stage of an elastic register pipeline. It holds a valid bit
//           and a data word, and advances whenever it is empty or the next
//           stage can take its word.
// Ports   : clk, rst     - clock, asynchronous active-high reset
//           flush        - synchronous discard (clears valid, and clears data
//                          too when CLEAR_ON_FLUSH = 1)
//           up_valid/up_data - word offered by the upstream side
//           down_ready   - downstream side can accept this stage's word
//           valid/data   - stage contents
//           ready        - this stage can load a new word this cycle
// Revision: 1.0 - initial release
// ============================================================================
module register_stage_elastic #(
  parameter int WIDTH          = 16,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // An empty stage always accepts. A full stage accepts only if its current
  // word moves on in the same cycle, which lets bubbles collapse.
  assign ready = !valid | down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        data <= '0;
      end
    end else if (ready) begin
      valid <= up_valid;
      // On a bubble the old data is kept, so DOUT only changes when a real
      // word arrives.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_pipeline_elastic.sv
`default_nettype none
// ============================================================================
// Module  : register_pipeline_elastic
// Purpose : STAGES-deep elastic delay line with a valid/ready handshake per
//           stage, a synchronous flush and a registered occupancy count.
// Ports   : CLK, RESET           - clock, asynchronous active-high reset
//           FLUSH                - synchronous discard of all stage contents
//           IN_VALID/IN_READY/DIN    - upstream handshake and data
//           OUT_VALID/OUT_READY/DOUT - downstream handshake and data
//           OCCUPANCY            - number of valid stages
// Revision: 1.0 - initial release
// ============================================================================
module register_pipeline_elastic
  import dnnweaver_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int STAGES         = 3,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [WIDTH-1:0]             DIN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [WIDTH-1:0]             DOUT,
  output logic [clog2(STAGES+1)-1:0]   OCCUPANCY
);

  localparam int              OCC_W   = clog2(STAGES + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // chain_*[i] is the word offered to stage i; chain_*[STAGES] is the output.
  // ready[i] is stage i's ready; ready[STAGES] is the downstream ready.
  logic [STAGES:0] chain_valid;
  logic [WIDTH-1:0] chain_data [STAGES+1];
  logic [STAGES:0] ready;

  logic in_xfer;
  logic out_xfer;

  assign chain_valid[0] = IN_VALID;
  assign chain_data[0]  = DIN;
  assign ready[STAGES]  = OUT_READY;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    register_stage_elastic #(
      .WIDTH          (WIDTH),
      .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_stage (
      .clk        (CLK),
      .rst        (RESET),
      .flush      (FLUSH),
      .up_valid   (chain_valid[i]),
      .up_data    (chain_data[i]),
      .down_ready (ready[i+1]),
      .valid      (chain_valid[i+1]),
      .data       (chain_data[i+1]),
      .ready      (ready[i])
    );
  end

  // FLUSH blocks both handshakes so nothing is counted or lost in that cycle.
  assign IN_READY  = ready[0] & !FLUSH;
  assign OUT_VALID = chain_valid[STAGES] & !FLUSH;
  assign DOUT      = chain_data[STAGES];

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = OUT_VALID & OUT_READY;

  // Tracked incrementally rather than by popcount so the output is a plain
  // register with no adder tree behind it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OCCUPANCY <= '0;
    end else if (FLUSH) begin
      OCCUPANCY <= '0;
    end else if (in_xfer && !out_xfer) begin
      OCCUPANCY <= OCCUPANCY + OCC_ONE;
    end else if (out_xfer && !in_xfer) begin
      OCCUPANCY <= OCCUPANCY - OCC_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_pipeline_elastic.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_pipeline_elastic
// Purpose : Self-checking bench for register_pipeline_elastic. Three copies
//           share one stimulus: STAGES=3 (scoreboarded), STAGES=3 with
//           CLEAR_ON_FLUSH=1, and STAGES=1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_register_pipeline_elastic;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             out_ready;

  logic             in_ready,   out_valid;
  logic [WIDTH-1:0] dout;
  logic [1:0]       occ;

  logic             c_in_ready, c_out_valid;
  logic [WIDTH-1:0] c_dout;
  logic [1:0]       c_occ;

  logic             s1_in_ready, s1_out_valid;
  logic [WIDTH-1:0] s1_dout;
  logic [0:0]       s1_occ;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  register_pipeline_elastic #(.WIDTH(WIDTH), .STAGES(3), .CLEAR_ON_FLUSH(1'b0)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
    .DIN(din), .OUT_VALID(out_valid), .OUT_READY(out_ready), .DOUT(dout), .OCCUPANCY(occ));

  register_pipeline_elastic #(.WIDTH(WIDTH), .STAGES(3), .CLEAR_ON_FLUSH(1'b1)) dut_clr (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(c_in_ready),
    .DIN(din), .OUT_VALID(c_out_valid), .OUT_READY(out_ready), .DOUT(c_dout), .OCCUPANCY(c_occ));

  register_pipeline_elastic #(.WIDTH(WIDTH), .STAGES(1), .CLEAR_ON_FLUSH(1'b0)) dut_s1 (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(s1_in_ready),
    .DIN(din), .OUT_VALID(s1_out_valid), .OUT_READY(out_ready), .DOUT(s1_dout), .OCCUPANCY(s1_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Scoreboard: accepted words are queued, delivered words must match in order.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: dout=%h delivered, required no output", dout);
        end else begin
          logic [WIDTH-1:0] exp;
          exp = exp_q.pop_front();
          if (dout !== exp) begin
            errors++;
            $display("FAIL sb_order: dout=%h, required %h", dout, exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(din);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; din = 16'hABCD; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: %h, required 0000", dout); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ: %0d, required 0", occ); end
    checks++; if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s1_out_valid: %b, required 0", s1_out_valid); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      in_valid = 1'b1; din = WIDTH'(j + 1);
      #1;
      checks++;
      if (out_valid !== (j >= 3)) begin errors++; $display("FAIL stream_out_valid[%0d]: %b, required %b", j, out_valid, (j >= 3)); end
      if (j >= 3) begin
        checks++;
        if (dout !== WIDTH'(j - 2)) begin errors++; $display("FAIL stream_latency[%0d]: dout=%h, required %h", j, dout, WIDTH'(j - 2)); end
      end
      checks++;
      if (occ !== 2'((j > 3) ? 3 : j)) begin errors++; $display("FAIL stream_occ[%0d]: %0d, required %0d", j, occ, (j > 3) ? 3 : j); end
    end
    step(); in_valid = 1'b0;
    repeat (4) step();
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: occ=%0d out_valid=%b, required 0 0", occ, out_valid); end
  endtask

  task automatic test_backpressure();
    step(); out_ready = 1'b0; in_valid = 1'b1; din = 16'h0011;
    step(); in_valid = 1'b0;
    step(); in_valid = 1'b1; din = 16'h0022;
    step(); din = 16'h0033;
    step(); in_valid = 1'b0;
    #1;
    checks++; if (occ !== 2'd3) begin errors++; $display("FAIL bp_occ: %0d, required 3", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || dout !== 16'h0011) begin errors++; $display("FAIL bp_head: valid=%b dout=%h, required 1 0011", out_valid, dout); end
    // Full pipe: release backpressure and offer a new word in the same cycle.
    out_ready = 1'b1; in_valid = 1'b1; din = 16'h0044;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: %b, required 1", in_ready); end
    step(); in_valid = 1'b0;
    #1;
    checks++; if (occ !== 2'd3) begin errors++; $display("FAIL full_simul_occ: %0d, required 3", occ); end
    checks++; if (dout !== 16'h0022) begin errors++; $display("FAIL full_simul_dout: %h, required 0022", dout); end
    repeat (5) step();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL bp_drain_occ: %0d, required 0", occ); end
  endtask

  task automatic test_flush();
    step(); out_ready = 1'b0; in_valid = 1'b1; din = 16'h0055;
    step(); din = 16'h0066;
    step(); in_valid = 1'b0;
    step(); flush = 1'b1; in_valid = 1'b1; din = 16'h0077;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: %b, required 0", out_valid); end
    checks++; if (dout !== 16'h0055) begin errors++; $display("FAIL flush_pre_dout: %h, required 0055", dout); end
    step(); flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (occ !== 2'd0 || c_occ !== 2'd0) begin errors++; $display("FAIL flush_occ: %0d/%0d, required 0/0", occ, c_occ); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post_valid: %b, required 0", out_valid); end
    checks++; if (dout !== 16'h0055) begin errors++; $display("FAIL flush_keep_data: %h, required 0055", dout); end
    checks++; if (c_dout !== 16'h0) begin errors++; $display("FAIL flush_clear_data: %h, required 0000", c_dout); end
    out_ready = 1'b1;
    repeat (3) step();
    checks++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL flush_no_accept: valid=%b occ=%0d, required 0 0", out_valid, occ); end
  endtask

  task automatic test_async_reset();
    step(); out_ready = 1'b0; in_valid = 1'b1; din = 16'h0088;
    step(); din = 16'h0099;
    step(); in_valid = 1'b0;
    step();
    #1;
    checks++; if (out_valid !== 1'b1 || occ !== 2'd2) begin errors++; $display("FAIL ar_inflight: valid=%b occ=%0d, required 1 2", out_valid, occ); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: %b, required 0", out_valid); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL ar_occ: %0d, required 0", occ); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL ar_dout: %h, required 0000", dout); end
    #2 rst = 1'b0;
    step();
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ar_after: occ=%0d valid=%b ready=%b, required 0 0 1", occ, out_valid, in_ready);
    end
  endtask

  task automatic test_stages1();
    step(); out_ready = 1'b0; in_valid = 1'b1; din = 16'h00A1;
    #1;
    checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL s1_ready_empty: %b, required 1", s1_in_ready); end
    step(); in_valid = 1'b0;
    #1;
    checks++; if (s1_out_valid !== 1'b1 || s1_dout !== 16'h00A1) begin errors++; $display("FAIL s1_latency: valid=%b dout=%h, required 1 00a1", s1_out_valid, s1_dout); end
    checks++; if (s1_in_ready !== 1'b0 || s1_occ !== 1'b1) begin errors++; $display("FAIL s1_full: ready=%b occ=%0d, required 0 1", s1_in_ready, s1_occ); end
    step();
    checks++; if (s1_out_valid !== 1'b1 || s1_dout !== 16'h00A1) begin errors++; $display("FAIL s1_hold: valid=%b dout=%h, required 1 00a1", s1_out_valid, s1_dout); end
    out_ready = 1'b1;
    #1;
    checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL s1_ready_pass: %b, required 1", s1_in_ready); end
    step();
    checks++; if (s1_out_valid !== 1'b0 || s1_occ !== 1'b0) begin errors++; $display("FAIL s1_empty: valid=%b occ=%0d, required 0 0", s1_out_valid, s1_occ); end
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stages1();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d words undelivered, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
